// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC generation, req/gnt/rvalid memory handshake, prefetch FIFO feeding IF/ID.
// Optional IF_PERF_CNT_EN adds fetched/bubble performance counters.
module if_fetch_stage #(
    parameter logic [8:0]  RESET_PC   = 9'h000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [8:0]  redirect_pc_i,
    output logic        imem_req_o,
    output logic [8:0]  imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [8:0]  ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_bubble_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

    logic [8:0]    pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [AW-1:0] rpc_wr;
    logic [AW-1:0] rpc_rd;
    logic [8:0]    fifo_pc_mem    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_mem [FIFO_DEPTH];
    logic [8:0]    rpc_mem        [FIFO_DEPTH];

    logic [CW:0]   credits_used;
    logic          req;
    logic          grant;
    logic          resp_keep;
    logic          advance;
    logic          fifo_empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [8:0]    resp_pc;
    logic          unused_pc_bits;

    // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
    assign credits_used    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req             = !reset && !redirect_i && (credits_used < LIMIT);
    assign grant           = req && imem_gnt_i;
    assign resp_pc         = rpc_mem[rpc_rd];
    assign resp_keep       = imem_rvalid_i && !redirect_i && (discard == '0);
    assign advance         = !stall_i && !redirect_i;
    assign fifo_empty      = (fifo_count == '0);
    assign bypass          = advance && fifo_empty && resp_keep;
    assign push            = resp_keep && !bypass;
    assign pop             = advance && !fifo_empty;
    assign outstanding_nxt = outstanding + CW'(grant) - CW'(imem_rvalid_i);
    assign unused_pc_bits  = ^redirect_pc_i[1:0];

    assign imem_req_o  = req;
    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_mem[fifo_wr]    <= resp_pc;
            fifo_instr_mem[fifo_wr] <= imem_rdata_i;
        end
        if (grant) begin
            rpc_mem[rpc_wr] <= pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            outstanding  <= '0;
            discard      <= '0;
            fifo_count   <= '0;
            fifo_wr      <= '0;
            fifo_rd      <= '0;
            rpc_wr       <= '0;
            rpc_rd       <= '0;
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_instr_o <= NOP_INSTR;
        end else begin
            outstanding <= outstanding_nxt;
            if (grant) begin
                rpc_wr <= rpc_wr + 1'b1;
            end
            if (imem_rvalid_i) begin
                rpc_rd <= rpc_rd + 1'b1;
            end
            if (redirect_i) begin
                // Every request still in flight after this edge belongs to the wrong path.
                pc           <= {redirect_pc_i[8:2], 2'b00};
                discard      <= outstanding_nxt;
                fifo_wr      <= '0;
                fifo_rd      <= '0;
                fifo_count   <= '0;
                ifid_valid_o <= 1'b0;
                ifid_instr_o <= NOP_INSTR;
            end else begin
                if (grant) begin
                    pc <= pc + 9'd4;
                end
                if (imem_rvalid_i && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    fifo_wr <= fifo_wr + 1'b1;
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + 1'b1;
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (advance) begin
                    if (pop) begin
                        ifid_valid_o <= 1'b1;
                        ifid_pc_o    <= fifo_pc_mem[fifo_rd];
                        ifid_instr_o <= fifo_instr_mem[fifo_rd];
                    end else if (bypass) begin
                        ifid_valid_o <= 1'b1;
                        ifid_pc_o    <= resp_pc;
                        ifid_instr_o <= imem_rdata_i;
                    end else begin
                        ifid_valid_o <= 1'b0;
                        ifid_instr_o <= NOP_INSTR;
                    end
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_o <= '0;
            perf_bubble_o  <= '0;
        end else if (advance) begin
            if (pop || bypass) begin
                perf_fetched_o <= perf_fetched_o + 32'd1;
            end else begin
                perf_bubble_o <= perf_bubble_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order instruction memory model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i;
    logic        redirect_i;
    logic [8:0]  redirect_pc_i;
    logic        imem_req_o;
    logic [8:0]  imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [8:0]  ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_bubble_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] pend[$];
    bit auto_resp;
    int n;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_valid_o  (ifid_valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched_o(perf_fetched_o),
        .perf_bubble_o (perf_bubble_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: record a grant, let the edge pass, then present the oldest pending response.
    task automatic cycle();
        #1;
        if (imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
        @(posedge clk);
        #1;
        if (auto_resp && pend.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit auto_mode);
        reset         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 9'h0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        auto_resp     = auto_mode;
        pend.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 9'h0;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; auto_resp = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("rst_req",   {31'd0, imem_req_o},   32'd0);
        check("rst_valid", {31'd0, ifid_valid_o}, 32'd0);
        check("rst_pc",    {23'd0, ifid_pc_o},    32'd0);
        check("rst_instr", ifid_instr_o,          NOP);

        // Streaming with single-cycle memory
        do_reset(1'b1);
        #1 check("t1_addr0", {23'd0, imem_addr_o}, 32'h000);
        n = 0;
        while (!ifid_valid_o && n < 10) begin cycle(); n++; end
        check("t1_first_lat", n, 2);
        for (int i = 0; i < 6; i++) begin
            check("t1_valid", {31'd0, ifid_valid_o}, 32'd1);
            check("t1_pc",    {23'd0, ifid_pc_o},    32'(i * 4));
            check("t1_instr", ifid_instr_o,          mem_word(9'(i * 4)));
            cycle();
        end

        // Stall holds IF/ID, requests stop at the credit limit, no gap after release
        do_reset(1'b1);
        n = 0;
        while (!(ifid_valid_o && ifid_pc_o == 9'h008) && n < 20) begin cycle(); n++; end
        check("t2_reach8", {23'd0, ifid_pc_o}, 32'h008);
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_hold_pc",    {23'd0, ifid_pc_o},    32'h008);
            check("t2_hold_valid", {31'd0, ifid_valid_o}, 32'd1);
        end
        check("t2_req_off", {31'd0, imem_req_o}, 32'd0);
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_rel_valid", {31'd0, ifid_valid_o}, 32'd1);
            check("t2_rel_pc",    {23'd0, ifid_pc_o},    32'(12 + i * 4));
        end

        // Redirect with two requests in flight
        do_reset(1'b0);
        redirect_i = 1'b1; redirect_pc_i = 9'h010;
        cycle();
        redirect_i = 1'b0;
        cycle();
        cycle();
        check("t3_credits_out", {31'd0, imem_req_o}, 32'd0);
        check("t3_inflight", pend.size(), 2);
        redirect_i = 1'b1; redirect_pc_i = 9'h040; auto_resp = 1'b1;
        cycle();
        check("t3_flush_valid", {31'd0, ifid_valid_o}, 32'd0);
        check("t3_flush_instr", ifid_instr_o, NOP);
        redirect_i = 1'b0;
        n = 0;
        while (!ifid_valid_o && n < 10) begin cycle(); n++; end
        check("t3_bubble", {31'd0, n >= 1}, 32'd1);
        check("t3_new_pc", {23'd0, ifid_pc_o}, 32'h040);
        check("t3_new_instr", ifid_instr_o, mem_word(9'h040));

        // PC wrap; low redirect bits are ignored
        do_reset(1'b1);
        redirect_i = 1'b1; redirect_pc_i = 9'h1FE;
        cycle();
        redirect_i = 1'b0;
        #1 check("t4_addr_1fc", {23'd0, imem_addr_o}, 32'h1FC);
        cycle();
        check("t4_addr_wrap", {23'd0, imem_addr_o}, 32'h000);
        cycle();
        check("t4_ifid_1fc", {23'd0, ifid_pc_o}, 32'h1FC);
        cycle();
        check("t4_ifid_000", {23'd0, ifid_pc_o}, 32'h000);
        check("t4_instr_000", ifid_instr_o, mem_word(9'h000));

        // Redirect beats stall and drops the same-cycle response
        do_reset(1'b1);
        n = 0;
        while (!ifid_valid_o && n < 10) begin cycle(); n++; end
        check("t5_rvalid_live", {31'd0, imem_rvalid_i}, 32'd1);
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 9'h080;
        cycle();
        check("t5_flush_valid", {31'd0, ifid_valid_o}, 32'd0);
        check("t5_flush_instr", ifid_instr_o, NOP);
        redirect_i = 1'b0; stall_i = 1'b0;
        #1;
        check("t5_req",  {31'd0, imem_req_o},  32'd1);
        check("t5_addr", {23'd0, imem_addr_o}, 32'h080);
        n = 0;
        while (!ifid_valid_o && n < 10) begin cycle(); n++; end
        check("t5_new_pc", {23'd0, ifid_pc_o}, 32'h080);
        check("t5_new_instr", ifid_instr_o, mem_word(9'h080));

        // Asynchronous reset in mid-stream
        do_reset(1'b1);
        n = 0;
        while (!(ifid_valid_o && ifid_pc_o == 9'h008) && n < 20) begin cycle(); n++; end
        stall_i = 1'b1; auto_resp = 1'b0;
        cycle();
        cycle();
        check("t6_pre_valid", {31'd0, ifid_valid_o}, 32'd1);
        check("t6_pre_pc",    {23'd0, ifid_pc_o},    32'h008);
        #2 reset = 1'b1;
        #1;
        check("t6_async_req",   {31'd0, imem_req_o},   32'd0);
        check("t6_async_valid", {31'd0, ifid_valid_o}, 32'd0);
        check("t6_async_pc",    {23'd0, ifid_pc_o},    32'd0);
        check("t6_async_instr", ifid_instr_o,          NOP);
        pend.delete();
        imem_rvalid_i = 1'b0;
        stall_i = 1'b0; auto_resp = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_post_req",  {31'd0, imem_req_o},  32'd1);
        check("t6_post_addr", {23'd0, imem_addr_o}, 32'h000);
        n = 0;
        while (!ifid_valid_o && n < 10) begin cycle(); n++; end
        check("t6_post_pc", {23'd0, ifid_pc_o}, 32'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
